// File: rtl/state_seq_pkg.sv
// state_seq_pkg
//   Shared types for the state-code sequence checker: the 2-bit state code
//   enum, the checker FSM encoding, the sequence end points and a helper that
//   steps a state code with 2-bit wrap.
package state_seq_pkg;

    typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

    typedef enum logic [1:0] {WAIT_FIRST, TRACK, HALT} chk_fsm_t;

    localparam state_t SEQ_FIRST = S0;
    localparam state_t SEQ_LAST  = S3;

    // Successor of a state code; S3 wraps to S0.
    function automatic state_t next_code(input state_t s);
        logic [1:0] t;
        t = s + 2'd1;
        return state_t'(t);
    endfunction

endpackage

// File: rtl/state_seq_checker_sat_counter.sv
// sat_counter
//   Saturating up-counter. Holds at all-ones instead of wrapping.
//   Ports:
//     clk   in   clock, rising edge
//     rst_n in   asynchronous active-low reset (count -> 0)
//     clr   in   synchronous clear, wins over inc
//     inc   in   increment request for this cycle
//     cnt   out  W-bit count
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/state_seq_checker.sv
// state_seq_checker
//   Protocol monitor for a 2-bit enum stepping sequencer. Samples qualified
//   state codes and checks they arrive as S0 -> S1 -> S2 -> S3, flagging
//   illegal codes and counting completed sequences and errors.
//   Optional build macro: STATE_SEQ_CHK_STICKY_ERR_EN adds err_sticky and
//   makes the first error halt the checker.
//   Ports:
//     clk        in   clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     clr        in   synchronous clear (same values as reset)
//     code_valid in   code qualifier
//     code       in   2-bit state code (state_t encoding)
//     cur_state  out  last accepted state
//     exp_state  out  next expected state
//     seq_done   out  one-cycle pulse when S3 completes a sequence
//     err        out  one-cycle pulse on an illegal code
//     halted     out  high while the checker is halted
//     done_cnt   out  saturating completed-sequence count
//     err_cnt    out  saturating error count
//     err_sticky out  (macro only) set by any error, cleared by clr/rst_n
module state_seq_checker
    import state_seq_pkg::*;
#(
    parameter int unsigned CNT_W        = 8,
    parameter bit          WRAP         = 1'b1,
    parameter bit          ALLOW_REPEAT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             code_valid,
    input  logic [1:0]       code,
    output state_t           cur_state,
    output state_t           exp_state,
    output logic             seq_done,
    output logic             err,
    output logic             halted,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] err_cnt
`ifdef STATE_SEQ_CHK_STICKY_ERR_EN
    ,
    output logic             err_sticky
`endif
);

    chk_fsm_t fsm_q, fsm_nxt;
    state_t   cur_q, cur_nxt;
    state_t   exp_q, exp_nxt;
    logic     done_nxt;
    logic     err_nxt;
    logic     halted_q;
    logic     seq_done_q;
    logic     err_q;
    state_t   code_st;

    assign code_st = state_t'(code);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= WAIT_FIRST;
            cur_q      <= S0;
            exp_q      <= S0;
            seq_done_q <= 1'b0;
            err_q      <= 1'b0;
            halted_q   <= 1'b0;
        end else if (clr) begin
            fsm_q      <= WAIT_FIRST;
            cur_q      <= S0;
            exp_q      <= S0;
            seq_done_q <= 1'b0;
            err_q      <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            fsm_q      <= fsm_nxt;
            cur_q      <= cur_nxt;
            exp_q      <= exp_nxt;
            seq_done_q <= done_nxt;
            err_q      <= err_nxt;
            halted_q   <= (fsm_nxt == HALT);
        end
    end

    always_comb begin
        fsm_nxt  = fsm_q;
        cur_nxt  = cur_q;
        exp_nxt  = exp_q;
        done_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (code_valid) begin
            case (fsm_q)
                WAIT_FIRST: begin
                    if (code_st == SEQ_FIRST) begin
                        cur_nxt = SEQ_FIRST;
                        exp_nxt = next_code(SEQ_FIRST);
                        fsm_nxt = TRACK;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                TRACK: begin
                    if (code_st == exp_q) begin
                        cur_nxt = code_st;
                        exp_nxt = next_code(code_st);
                        if (code_st == SEQ_LAST) begin
                            done_nxt = 1'b1;
                            if (!WRAP) begin
                                fsm_nxt = HALT;
                            end
                        end
                    end else if (ALLOW_REPEAT && (code_st == cur_q)) begin
                        // repeat of the last accepted code: ignored
                    end else begin
                        err_nxt = 1'b1;
                        // An S0 can restart a sequence immediately; anything
                        // else must wait for a fresh S0.
                        if (code_st == SEQ_FIRST) begin
                            cur_nxt = SEQ_FIRST;
                            exp_nxt = next_code(SEQ_FIRST);
                        end else begin
                            fsm_nxt = WAIT_FIRST;
                            exp_nxt = SEQ_FIRST;
                        end
                    end
                end
                HALT: begin
                    // codes are ignored until clr or rst_n
                end
                default: begin
                    fsm_nxt = WAIT_FIRST;
                end
            endcase
        end
`ifdef STATE_SEQ_CHK_STICKY_ERR_EN
        if (err_nxt) begin
            fsm_nxt = HALT;
        end
`endif
    end

`ifdef STATE_SEQ_CHK_STICKY_ERR_EN
    logic sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (clr) begin
            sticky_q <= 1'b0;
        end else if (err_nxt) begin
            sticky_q <= 1'b1;
        end
    end

    assign err_sticky = sticky_q;
`endif

    // Counters update on the same edge as the pulses they count.
    sat_counter #(.W(CNT_W)) u_done_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (done_nxt),
        .cnt   (done_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (err_nxt),
        .cnt   (err_cnt)
    );

    assign cur_state = cur_q;
    assign exp_state = exp_q;
    assign seq_done  = seq_done_q;
    assign err       = err_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_state_seq_checker.sv
module tb_state_seq_checker;
    import state_seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       code_valid;
    logic [1:0] code;

    int unsigned pass_cnt;
    int unsigned total_cnt;

    // default instance: WRAP=1, ALLOW_REPEAT=1, CNT_W=8
    state_t     a_cur, a_exp;
    logic       a_done, a_err, a_halt;
    logic [7:0] a_dcnt, a_ecnt;
    // ALLOW_REPEAT=0
    state_t     r_cur, r_exp;
    logic       r_done, r_err, r_halt;
    logic [7:0] r_dcnt, r_ecnt;
    // WRAP=0
    state_t     w_cur, w_exp;
    logic       w_done, w_err, w_halt;
    logic [7:0] w_dcnt, w_ecnt;
    // CNT_W=2
    state_t     c_cur, c_exp;
    logic       c_done, c_err, c_halt;
    logic [1:0] c_dcnt, c_ecnt;
`ifdef STATE_SEQ_CHK_STICKY_ERR_EN
    logic a_stk, r_stk, w_stk, c_stk;
`endif

    state_seq_checker dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .code_valid(code_valid), .code(code),
        .cur_state(a_cur), .exp_state(a_exp), .seq_done(a_done), .err(a_err),
        .halted(a_halt), .done_cnt(a_dcnt), .err_cnt(a_ecnt)
`ifdef STATE_SEQ_CHK_STICKY_ERR_EN
        , .err_sticky(a_stk)
`endif
    );

    state_seq_checker #(.ALLOW_REPEAT(1'b0)) dut_r (
        .clk(clk), .rst_n(rst_n), .clr(clr), .code_valid(code_valid), .code(code),
        .cur_state(r_cur), .exp_state(r_exp), .seq_done(r_done), .err(r_err),
        .halted(r_halt), .done_cnt(r_dcnt), .err_cnt(r_ecnt)
`ifdef STATE_SEQ_CHK_STICKY_ERR_EN
        , .err_sticky(r_stk)
`endif
    );

    state_seq_checker #(.WRAP(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .clr(clr), .code_valid(code_valid), .code(code),
        .cur_state(w_cur), .exp_state(w_exp), .seq_done(w_done), .err(w_err),
        .halted(w_halt), .done_cnt(w_dcnt), .err_cnt(w_ecnt)
`ifdef STATE_SEQ_CHK_STICKY_ERR_EN
        , .err_sticky(w_stk)
`endif
    );

    state_seq_checker #(.CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .code_valid(code_valid), .code(code),
        .cur_state(c_cur), .exp_state(c_exp), .seq_done(c_done), .err(c_err),
        .halted(c_halt), .done_cnt(c_dcnt), .err_cnt(c_ecnt)
`ifdef STATE_SEQ_CHK_STICKY_ERR_EN
        , .err_sticky(c_stk)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n      = 1'b0;
        clr        = 1'b0;
        code_valid = 1'b0;
        code       = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one code for one edge, then settle just after the edge.
    task automatic step(input logic v, input logic [1:0] c);
        @(negedge clk);
        code_valid = v;
        code       = c;
        clr        = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({a_cur, a_exp, a_done, a_err, a_halt, a_dcnt, a_ecnt} !== {S0, S0, 3'b000, 8'd0, 8'd0})
            $display("FAIL reset_values: got cur=%0d exp=%0d done=%b err=%b halt=%b dcnt=%0d ecnt=%0d, want all zero",
                     a_cur, a_exp, a_done, a_err, a_halt, a_dcnt, a_ecnt);
        else pass_cnt++;
    endtask

    task automatic test_full_sequence();
        do_reset();
        step(1'b1, 2'd0);
        step(1'b1, 2'd1);
        step(1'b1, 2'd2);
        total_cnt++;
        if (a_done !== 1'b0) $display("FAIL seq_done_early: got %b want 0", a_done);
        else pass_cnt++;
        step(1'b1, 2'd3);
        total_cnt++;
        if ({a_done, a_err} !== 2'b10) $display("FAIL seq_done_pulse: got done=%b err=%b want 1 0", a_done, a_err);
        else pass_cnt++;
        total_cnt++;
        if (a_dcnt !== 8'd1 || a_exp !== S0 || a_cur !== S3)
            $display("FAIL seq_complete_state: got dcnt=%0d exp=%0d cur=%0d want 1 0 3", a_dcnt, a_exp, a_cur);
        else pass_cnt++;
        step(1'b0, 2'd0);
        total_cnt++;
        if (a_done !== 1'b0 || a_dcnt !== 8'd1) $display("FAIL seq_done_one_cycle: got done=%b dcnt=%0d want 0 1", a_done, a_dcnt);
        else pass_cnt++;
    endtask

    task automatic test_wait_first();
        do_reset();
        step(1'b1, 2'd2);
        total_cnt++;
        if (a_err !== 1'b1 || a_ecnt !== 8'd1) $display("FAIL wait_first_err1: got err=%b ecnt=%0d want 1 1", a_err, a_ecnt);
        else pass_cnt++;
        step(1'b1, 2'd1);
        total_cnt++;
        if (a_err !== 1'b1 || a_ecnt !== 8'd2) $display("FAIL wait_first_err2: got err=%b ecnt=%0d want 1 2", a_err, a_ecnt);
        else pass_cnt++;
        step(1'b1, 2'd0);
        total_cnt++;
        if (a_err !== 1'b0 || a_exp !== S1 || a_cur !== S0 || a_ecnt !== 8'd2)
            $display("FAIL wait_first_accept: got err=%b exp=%0d cur=%0d ecnt=%0d want 0 1 0 2", a_err, a_exp, a_cur, a_ecnt);
        else pass_cnt++;
    endtask

    task automatic test_illegal_jump();
        do_reset();
        step(1'b1, 2'd0);
        step(1'b1, 2'd1);
        step(1'b1, 2'd3);
        total_cnt++;
        if (a_err !== 1'b1 || a_ecnt !== 8'd1 || a_exp !== S0)
            $display("FAIL jump_err: got err=%b ecnt=%0d exp=%0d want 1 1 0", a_err, a_ecnt, a_exp);
        else pass_cnt++;
        // back in WAIT_FIRST: a 1 must now be an error
        step(1'b1, 2'd1);
        total_cnt++;
        if (a_err !== 1'b1 || a_ecnt !== 8'd2) $display("FAIL jump_wait_first: got err=%b ecnt=%0d want 1 2", a_err, a_ecnt);
        else pass_cnt++;
        step(1'b1, 2'd0);
        total_cnt++;
        if (a_err !== 1'b0 || a_exp !== S1 || a_ecnt !== 8'd2)
            $display("FAIL jump_resync: got err=%b exp=%0d ecnt=%0d want 0 1 2", a_err, a_exp, a_ecnt);
        else pass_cnt++;
        // S0 while tracking: error but resync in place
        step(1'b1, 2'd1);
        step(1'b1, 2'd0);
        total_cnt++;
        if (a_err !== 1'b1 || a_exp !== S1 || a_cur !== S0 || a_ecnt !== 8'd3)
            $display("FAIL track_s0_resync: got err=%b exp=%0d cur=%0d ecnt=%0d want 1 1 0 3", a_err, a_exp, a_cur, a_ecnt);
        else pass_cnt++;
        step(1'b1, 2'd1);
        total_cnt++;
        if (a_err !== 1'b0 || a_exp !== S2) $display("FAIL track_after_resync: got err=%b exp=%0d want 0 2", a_err, a_exp);
        else pass_cnt++;
    endtask

    task automatic test_repeat();
        logic [1:0] seq [6];
        int unsigned a_err_seen;
        seq[0] = 2'd0; seq[1] = 2'd0; seq[2] = 2'd1;
        seq[3] = 2'd1; seq[4] = 2'd2; seq[5] = 2'd3;
        a_err_seen = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, seq[i]);
            if (a_err === 1'b1) a_err_seen++;
        end
        total_cnt++;
        if (a_err_seen != 0 || a_ecnt !== 8'd0 || a_dcnt !== 8'd1)
            $display("FAIL repeat_allowed: got err_pulses=%0d ecnt=%0d dcnt=%0d want 0 0 1", a_err_seen, a_ecnt, a_dcnt);
        else pass_cnt++;
        // no-repeat instance: 0 ok, 0 err (resync), 1 ok, 1 err (-> WAIT_FIRST), 2 err, 3 err
        total_cnt++;
        if (r_ecnt !== 8'd4 || r_dcnt !== 8'd0)
            $display("FAIL repeat_forbidden: got ecnt=%0d dcnt=%0d want 4 0", r_ecnt, r_dcnt);
        else pass_cnt++;
    endtask

    task automatic test_halt_and_clr();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 2'(i));
        total_cnt++;
        if (w_done !== 1'b1 || w_halt !== 1'b1 || w_dcnt !== 8'd1)
            $display("FAIL nowrap_halt: got done=%b halt=%b dcnt=%0d want 1 1 1", w_done, w_halt, w_dcnt);
        else pass_cnt++;
        step(1'b1, 2'd0);
        step(1'b1, 2'd1);
        total_cnt++;
        if (w_halt !== 1'b1 || w_dcnt !== 8'd1 || w_ecnt !== 8'd0 || w_err !== 1'b0 || w_cur !== S3)
            $display("FAIL halt_ignores: got halt=%b dcnt=%0d ecnt=%0d err=%b cur=%0d want 1 1 0 0 3",
                     w_halt, w_dcnt, w_ecnt, w_err, w_cur);
        else pass_cnt++;
        // clr with a valid code present: code is ignored
        @(negedge clk);
        clr        = 1'b1;
        code_valid = 1'b1;
        code       = 2'd0;
        @(posedge clk);
        #1;
        clr        = 1'b0;
        code_valid = 1'b0;
        total_cnt++;
        if (w_halt !== 1'b0 || w_dcnt !== 8'd0 || w_exp !== S0 || w_cur !== S0)
            $display("FAIL clr_values: got halt=%b dcnt=%0d exp=%0d cur=%0d want 0 0 0 0", w_halt, w_dcnt, w_exp, w_cur);
        else pass_cnt++;
        step(1'b1, 2'd1);
        total_cnt++;
        if (w_err !== 1'b1 || w_ecnt !== 8'd1) $display("FAIL clr_to_wait_first: got err=%b ecnt=%0d want 1 1", w_err, w_ecnt);
        else pass_cnt++;
    endtask

    task automatic test_saturation_and_async_reset();
        logic [1:0] want;
        do_reset();
        for (int s = 1; s <= 5; s++) begin
            for (int i = 0; i < 4; i++) step(1'b1, 2'(i));
            want = (s >= 3) ? 2'd3 : 2'(s);
            total_cnt++;
            if (c_dcnt !== want || c_done !== 1'b1)
                $display("FAIL sat_done_cnt_%0d: got dcnt=%0d done=%b want %0d 1", s, c_dcnt, c_done, want);
            else pass_cnt++;
        end
        step(1'b1, 2'd2);
        step(1'b1, 2'd0);
        step(1'b1, 2'd1);
        total_cnt++;
        if (c_ecnt !== 2'd1 || c_cur !== S1 || c_exp !== S2)
            $display("FAIL pre_reset_state: got ecnt=%0d cur=%0d exp=%0d want 1 1 2", c_ecnt, c_cur, c_exp);
        else pass_cnt++;
        // async reset between edges
        @(negedge clk);
        code_valid = 1'b1;
        code       = 2'd2;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({c_cur, c_exp, c_done, c_err, c_halt, c_dcnt, c_ecnt} !== {S0, S0, 3'b000, 2'd0, 2'd0})
            $display("FAIL async_reset: got cur=%0d exp=%0d done=%b err=%b halt=%b dcnt=%0d ecnt=%0d, want all zero",
                     c_cur, c_exp, c_done, c_err, c_halt, c_dcnt, c_ecnt);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (c_done !== 1'b0 || c_err !== 1'b0 || c_cur !== S0)
            $display("FAIL reset_held: got done=%b err=%b cur=%0d want 0 0 0", c_done, c_err, c_cur);
        else pass_cnt++;
        do_reset();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_full_sequence();
        test_wait_first();
        test_illegal_jump();
        test_repeat();
        test_halt_and_clr();
        test_saturation_and_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
